// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP draw front end.
package vdp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } draw_seq_state_t;

    localparam int LB_X_W      = 12;
    localparam int LB_X_STEP   = 8;
    localparam int DEF_FETCHES = 64;
    localparam int DEF_DRAIN   = 4;

endpackage

// File: rtl/draw_sequencer.sv
// Per-line tile fetch sequencer: issues a burst of fetch slots on each line
// pulse, waits for the pipeline to drain, and lends the BRAM port to the host while idle.
module draw_sequencer
    import vdp_pkg::*;
#(
    parameter int CORDW   = 11,
    parameter int FETCHES = DEF_FETCHES,
    parameter int DRAIN   = DEF_DRAIN
) (
    input  logic              clk_draw,
    input  logic              rst_draw,
    input  logic              line_start,
    input  logic              frame_start,
    input  logic [CORDW-1:0]  sy,
    input  logic [11:0]       scroll_x,
    input  logic              host_req,
    output logic              host_gnt,
    output logic              fetch_valid,
    output logic [4:0]        tile_map_x,
    output logic [4:0]        tile_map_y,
    output logic [2:0]        tile_row,
    output logic              tile_col,
    output logic [11:0]       lb_x,
    output logic              bufsel,
    output logic              pipe_flush,
    output logic              busy,
    output logic              line_done,
    output logic              overrun
);

    localparam int SLOT_W = $clog2(FETCHES) + 1;
    localparam int DRN_W  = $clog2(DRAIN) + 1;

    draw_seq_state_t     state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [DRN_W-1:0]    drain_q, drain_d;
    logic [LB_X_W-1:0]   scroll_q, scroll_d;
    logic [LB_X_W-1:0]   lb_x_q, lb_x_d;
    logic                fetch_valid_q, fetch_valid_d;
    logic [4:0]          tile_map_x_q, tile_map_x_d;
    logic [4:0]          tile_map_y_q, tile_map_y_d;
    logic [2:0]          tile_row_q, tile_row_d;
    logic                tile_col_q, tile_col_d;
    logic                bufsel_q, bufsel_d;
    logic                pipe_flush_q, pipe_flush_d;
    logic                busy_q, busy_d;
    logic                line_done_q, line_done_d;
    logic                overrun_q, overrun_d;

    logic unused_sy_hi;
    assign unused_sy_hi = ^sy[CORDW-1:9];

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        drain_d       = drain_q;
        lb_x_d        = lb_x_q;
        fetch_valid_d = fetch_valid_q;
        tile_map_x_d  = tile_map_x_q;
        tile_map_y_d  = tile_map_y_q;
        tile_row_d    = tile_row_q;
        tile_col_d    = tile_col_q;
        bufsel_d      = bufsel_q;
        pipe_flush_d  = 1'b0;
        line_done_d   = 1'b0;
        overrun_d     = 1'b0;
        // A scroll value arriving with the line pulse must already apply to that line.
        scroll_d      = frame_start ? scroll_x : scroll_q;

        case (state_q)
            ST_FETCH: begin
                if (slot_q == SLOT_W'(FETCHES - 1)) begin
                    state_d       = ST_DRAIN;
                    fetch_valid_d = 1'b0;
                    drain_d       = '0;
                end else begin
                    slot_d       = slot_q + 1'b1;
                    lb_x_d       = lb_x_q + LB_X_W'(LB_X_STEP);
                    tile_map_x_d = slot_d[5:1];
                    tile_col_d   = slot_d[0];
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRN_W'(DRAIN - 1)) begin
                    state_d     = ST_IDLE;
                    line_done_d = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: ;
        endcase

        // A line pulse always (re)starts the burst; mid-line it aborts the old one.
        if (line_start) begin
            overrun_d     = (state_q != ST_IDLE);
            line_done_d   = 1'b0;
            state_d       = ST_FETCH;
            slot_d        = '0;
            drain_d       = '0;
            lb_x_d        = scroll_d;
            fetch_valid_d = 1'b1;
            tile_map_x_d  = '0;
            tile_col_d    = 1'b0;
            tile_map_y_d  = sy[8:4];
            tile_row_d    = sy[3:1];
            bufsel_d      = sy[0];
            pipe_flush_d  = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            state_q       <= ST_IDLE;
            slot_q        <= '0;
            drain_q       <= '0;
            scroll_q      <= '0;
            lb_x_q        <= '0;
            fetch_valid_q <= 1'b0;
            tile_map_x_q  <= '0;
            tile_map_y_q  <= '0;
            tile_row_q    <= '0;
            tile_col_q    <= 1'b0;
            bufsel_q      <= 1'b0;
            pipe_flush_q  <= 1'b0;
            busy_q        <= 1'b0;
            line_done_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            drain_q       <= drain_d;
            scroll_q      <= scroll_d;
            lb_x_q        <= lb_x_d;
            fetch_valid_q <= fetch_valid_d;
            tile_map_x_q  <= tile_map_x_d;
            tile_map_y_q  <= tile_map_y_d;
            tile_row_q    <= tile_row_d;
            tile_col_q    <= tile_col_d;
            bufsel_q      <= bufsel_d;
            pipe_flush_q  <= pipe_flush_d;
            busy_q        <= busy_d;
            line_done_q   <= line_done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign host_gnt    = host_req && (state_q == ST_IDLE) && !line_start;
    assign fetch_valid = fetch_valid_q;
    assign tile_map_x  = tile_map_x_q;
    assign tile_map_y  = tile_map_y_q;
    assign tile_row    = tile_row_q;
    assign tile_col    = tile_col_q;
    assign lb_x        = lb_x_q;
    assign bufsel      = bufsel_q;
    assign pipe_flush  = pipe_flush_q;
    assign busy        = busy_q;
    assign line_done   = line_done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Scoreboard bench for draw_sequencer: stimulus pushes expected slot/done/overrun
// events with their cycle; a negedge monitor pops and compares them.
module tb_draw_sequencer;

    localparam int F = 64;
    localparam int D = 4;
    localparam int K_SLOT = 0;
    localparam int K_DONE = 1;
    localparam int K_OVR  = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] vec;
    } exp_t;

    logic        clk_draw = 1'b0;
    logic        rst_draw;
    logic        line_start, frame_start, host_req;
    logic [10:0] sy;
    logic [11:0] scroll_x;
    logic        host_gnt, fetch_valid, tile_col, bufsel, pipe_flush, busy, line_done, overrun;
    logic [4:0]  tile_map_x, tile_map_y;
    logic [2:0]  tile_row;
    logic [11:0] lb_x;

    exp_t        expq[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [11:0] scroll_m = 12'd0;

    draw_sequencer #(.CORDW(11), .FETCHES(F), .DRAIN(D)) dut (
        .clk_draw(clk_draw), .rst_draw(rst_draw),
        .line_start(line_start), .frame_start(frame_start),
        .sy(sy), .scroll_x(scroll_x),
        .host_req(host_req), .host_gnt(host_gnt),
        .fetch_valid(fetch_valid), .tile_map_x(tile_map_x), .tile_map_y(tile_map_y),
        .tile_row(tile_row), .tile_col(tile_col), .lb_x(lb_x), .bufsel(bufsel),
        .pipe_flush(pipe_flush), .busy(busy), .line_done(line_done), .overrun(overrun)
    );

    always #5 clk_draw = ~clk_draw;
    always @(posedge clk_draw) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_cmp(input int kind, input logic [31:0] act);
        exp_t e;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event kind=%0d got %h at cyc %0d", kind, act, cyc);
            return;
        end
        e = expq.pop_front();
        if (e.kind != kind || e.cyc != cyc || e.vec !== act) begin
            bad++;
            $display("FAIL event: got kind=%0d cyc=%0d vec=%h want kind=%0d cyc=%0d vec=%h",
                     kind, cyc, act, e.kind, e.cyc, e.vec);
        end
    endtask

    // Monitor: overrun, slot and done are independent in a cycle; pushed in that order.
    always @(negedge clk_draw) begin
        if (overrun) pop_cmp(K_OVR, {31'd0, busy});
        if (fetch_valid)
            pop_cmp(K_SLOT, {3'd0, busy, tile_map_x, tile_map_y, tile_row, tile_col,
                             lb_x, bufsel, pipe_flush});
        else if (pipe_flush)
            chk("flush_without_slot", {31'd0, pipe_flush}, 32'd0);
        if (line_done) pop_cmp(K_DONE, {30'd0, fetch_valid, busy});
    end

    task automatic push(input int kind, input int c, input logic [31:0] v);
        exp_t e;
        e.kind = kind; e.cyc = c; e.vec = v;
        expq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_draw); #1;
    endtask

    task automatic fstart(input logic [11:0] v);
        frame_start = 1'b1; scroll_x = v; scroll_m = v;
        step();
        frame_start = 1'b0;
    endtask

    // Called at posedge+1; the pulse is sampled on the next edge, so slot 0 shows at cyc+1.
    task automatic start_line(input logic [10:0] s, input int n, input bit done,
                              input bit ovr, input bit fs, input logic [11:0] sx);
        int          c0;
        logic [11:0] lbx;
        c0 = cyc + 1;
        line_start = 1'b1; sy = s;
        if (fs) begin
            frame_start = 1'b1; scroll_x = sx; scroll_m = sx;
        end
        if (ovr) push(K_OVR, c0, 32'd1);
        lbx = scroll_m;
        for (int i = 0; i < n; i++) begin
            push(K_SLOT, c0 + i, {3'd0, 1'b1, 5'(i >> 1), s[8:4], s[3:1], 1'(i & 1),
                                  lbx, s[0], (i == 0)});
            lbx = lbx + 12'd8;
        end
        if (done) push(K_DONE, c0 + F + D, 32'd0);
        #1;
        if (host_req) chk("gnt_during_line_start", {31'd0, host_gnt}, 32'd0);
        step();
        line_start = 1'b0; frame_start = 1'b0;
    endtask

    task automatic idle_wait();
        repeat (F + D + 4) step();
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, {8'd0, host_gnt, fetch_valid, tile_map_x, tile_map_y, tile_row, tile_col,
                   bufsel, pipe_flush, busy, line_done, overrun}, 32'd0);
        chk({name, "_lbx"}, {20'd0, lb_x}, 32'd0);
    endtask

    initial begin
        rst_draw = 1'b1; line_start = 1'b0; frame_start = 1'b0; host_req = 1'b0;
        sy = '0; scroll_x = '0;
        repeat (3) step();
        rst_draw = 1'b0;
        chk_outputs_zero("reset_state");

        host_req = 1'b1; #1;
        chk("gnt_idle", {31'd0, host_gnt}, 32'd1);
        host_req = 1'b0;

        // Basic line: sy=37 -> map_y 2, row 2, bufsel 1, lb_x from 0.
        fstart(12'd0);
        start_line(11'd37, F, 1, 0, 0, 12'd0);
        idle_wait();

        // Scroll wrap.
        fstart(12'd4090);
        start_line(11'd37, F, 1, 0, 0, 12'd0);
        idle_wait();

        // frame_start together with line_start uses the new scroll.
        start_line(11'd5, F, 1, 0, 1, 12'd16);
        idle_wait();

        // Overrun at cycle 30 with sy=38 (row 3, bufsel 0); only one line_done.
        fstart(12'd0);
        start_line(11'd37, 30, 0, 0, 0, 12'd0);
        repeat (29) step();
        start_line(11'd38, F, 1, 1, 0, 12'd0);
        idle_wait();

        // Arbitration across a full line.
        host_req = 1'b1; #1;
        chk("gnt_before_line", {31'd0, host_gnt}, 32'd1);
        start_line(11'd100, F, 1, 0, 0, 12'd0);
        for (int i = 0; i < F + D; i++) begin
            chk("gnt_busy", {31'd0, host_gnt}, 32'd0);
            step();
        end
        chk("gnt_at_done", {31'd0, host_gnt}, 32'd1);
        chk("done_with_gnt", {31'd0, line_done}, 32'd1);
        host_req = 1'b0;
        idle_wait();

        // Reset in FETCH: slot 19 is the last seen, then all zero with no line_done.
        start_line(11'd37, 20, 0, 0, 0, 12'd0);
        repeat (19) step();
        rst_draw = 1'b1;
        step();
        rst_draw = 1'b0;
        chk_outputs_zero("after_midline_reset");
        idle_wait();
        chk("queue_after_reset", expq.size(), 32'd0);

        // Scroll register was cleared by reset, so lb_x restarts from 0.
        scroll_m = 12'd0;
        start_line(11'd37, F, 1, 0, 0, 12'd0);
        idle_wait();

        chk("queue_empty", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
